// File: rtl/coffee_pkg.sv
// Shared types and constants for the coffee dispenser: FSM state encoding,
// default stage lengths and the counter width used by timers and cup_count.
package coffee_pkg;

  localparam int CNT_W        = 16;
  localparam int HEAT_CYC_DEF = 20;
  localparam int BREW_CYC_DEF = 30;
  localparam int POUR_CYC_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAT  = 3'd1,
    ST_BREW  = 3'd2,
    ST_POUR  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ABORT = 3'd5
  } state_e;

endpackage

// File: rtl/coffee_dispenser_stage_timer.sv
// Load/decrement down-counter shared by all dispenser stages; done is high
// during the last cycle of a loaded interval.
module stage_timer
  import coffee_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: reload wins, otherwise count down and park at zero.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (count_q != {CNT_W{1'b0}}) begin
      count_d = count_q - CNT_W'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= {CNT_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign done = (count_q == CNT_W'(1));

endmodule

// File: rtl/coffee_dispenser.sv
// Coffee dispenser sequencer: IDLE -> HEAT -> BREW -> POUR -> DONE on a coffee_make
// rising edge. Define DISPENSER_CUP_CHECK_EN to abort on a missing cup.
module coffee_dispenser #(
  parameter int HEAT_CYC = coffee_pkg::HEAT_CYC_DEF,
  parameter int BREW_CYC = coffee_pkg::BREW_CYC_DEF,
  parameter int POUR_CYC = coffee_pkg::POUR_CYC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        coffee_make,
  input  logic        cup_present,
  output logic        coffee_out,
  output logic        busy,
  output logic        heater_on,
  output logic        pump_on,
  output logic        valve_on,
  output logic        fault,
  output logic [15:0] cup_count
);
  import coffee_pkg::*;

  state_e           state_q, state_d;
  logic             make_prev_q;
  logic             req;
  logic             cup_ok;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_done;
  logic             coffee_out_q, busy_q, heater_on_q, pump_on_q, valve_on_q;
  logic [CNT_W-1:0] cup_count_q, cup_count_d;

`ifdef DISPENSER_CUP_CHECK_EN
  logic fault_q, fault_d;
  assign cup_ok = cup_present;
`else
  logic unused_cup;
  assign unused_cup = cup_present;
  assign cup_ok     = 1'b1;
`endif

  assign req = coffee_make & ~make_prev_q & (state_q == ST_IDLE);

  // Next-state logic; a missing cup takes priority over stage completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req) state_d = cup_ok ? ST_HEAT : ST_ABORT;
        else     state_d = ST_IDLE;
      end
      ST_HEAT: begin
        if (!cup_ok)         state_d = ST_ABORT;
        else if (timer_done) state_d = ST_BREW;
        else                 state_d = ST_HEAT;
      end
      ST_BREW: begin
        if (!cup_ok)         state_d = ST_ABORT;
        else if (timer_done) state_d = ST_POUR;
        else                 state_d = ST_BREW;
      end
      ST_POUR: begin
        if (!cup_ok)         state_d = ST_ABORT;
        else if (timer_done) state_d = ST_DONE;
        else                 state_d = ST_POUR;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Timer reloads on every state change so no partial count survives.
  always_comb begin
    timer_load = (state_d != state_q);
    case (state_d)
      ST_HEAT: timer_val = CNT_W'(HEAT_CYC);
      ST_BREW: timer_val = CNT_W'(BREW_CYC);
      ST_POUR: timer_val = CNT_W'(POUR_CYC);
      default: timer_val = {CNT_W{1'b0}};
    endcase
  end

  stage_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  // Saturating completed-dispense counter.
  always_comb begin
    cup_count_d = cup_count_q;
    if ((state_d == ST_DONE) && (cup_count_q != {CNT_W{1'b1}})) begin
      cup_count_d = cup_count_q + CNT_W'(1);
    end else begin
      cup_count_d = cup_count_q;
    end
  end

  // State, edge history and outputs registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      make_prev_q  <= 1'b0;
      coffee_out_q <= 1'b0;
      busy_q       <= 1'b0;
      heater_on_q  <= 1'b0;
      pump_on_q    <= 1'b0;
      valve_on_q   <= 1'b0;
      cup_count_q  <= {CNT_W{1'b0}};
    end else begin
      state_q      <= state_d;
      make_prev_q  <= coffee_make;
      coffee_out_q <= (state_d == ST_DONE) || (state_d == ST_ABORT);
      busy_q       <= (state_d != ST_IDLE);
      heater_on_q  <= (state_d == ST_HEAT);
      pump_on_q    <= (state_d == ST_BREW);
      valve_on_q   <= (state_d == ST_POUR);
      cup_count_q  <= cup_count_d;
    end
  end

`ifdef DISPENSER_CUP_CHECK_EN
  // Sticky fault: set on abort, cleared when a request is accepted into HEAT.
  always_comb begin
    fault_d = fault_q;
    if (state_d == ST_ABORT) begin
      fault_d = 1'b1;
    end else if ((state_q == ST_IDLE) && (state_d == ST_HEAT)) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

  // Fault register.
  always_ff @(posedge clk) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end

  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign coffee_out = coffee_out_q;
  assign busy       = busy_q;
  assign heater_on  = heater_on_q;
  assign pump_on    = pump_on_q;
  assign valve_on   = valve_on_q;
  assign cup_count  = cup_count_q;

endmodule

// File: tb/tb_coffee_dispenser.sv
// Directed bench for coffee_dispenser with default stage lengths (20/30/10).
module tb_coffee_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic        coffee_make;
  logic        cup_present;
  logic        coffee_out, busy, heater_on, pump_on, valve_on, fault;
  logic [15:0] cup_count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  coffee_dispenser dut (
    .clk         (clk),
    .reset       (reset),
    .coffee_make (coffee_make),
    .cup_present (cup_present),
    .coffee_out  (coffee_out),
    .busy        (busy),
    .heater_on   (heater_on),
    .pump_on     (pump_on),
    .valve_on    (valve_on),
    .fault       (fault),
    .cup_count   (cup_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; coffee_make = 1'b0; cup_present = 1'b1;
    repeat (10) tick();
    reset = 1'b0;
    tick();
    vectors++;
    if ({coffee_out, busy, heater_on, pump_on, valve_on, fault} !== 6'b000000) begin
      miscompares++;
      $display("FAIL reset_outputs got %b want 000000",
               {coffee_out, busy, heater_on, pump_on, valve_on, fault});
    end
    vectors++;
    if (cup_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_count got %0d want 0", cup_count);
    end
  endtask

  task automatic test_dispense();
    logic [3:0] exp_v;
    coffee_make = 1'b1;
    for (int k = 1; k <= 61; k++) begin
      tick();
      exp_v = (k <= 20) ? 4'b1000 : (k <= 50) ? 4'b0100 : (k <= 60) ? 4'b0010 : 4'b0001;
      vectors++;
      if ({heater_on, pump_on, valve_on, coffee_out} !== exp_v || busy !== 1'b1) begin
        miscompares++;
        $display("FAIL dispense_k%0d got hpvo=%b busy=%b want hpvo=%b busy=1",
                 k, {heater_on, pump_on, valve_on, coffee_out}, busy, exp_v);
      end
    end
    tick();
    vectors++;
    if (coffee_out !== 1'b0 || busy !== 1'b0 || cup_count !== 16'd1) begin
      miscompares++;
      $display("FAIL dispense_end got out=%b busy=%b count=%0d want 0 0 1",
               coffee_out, busy, cup_count);
    end
  endtask

  task automatic test_hold_no_retrigger();
    int bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (busy !== 1'b0 || coffee_out !== 1'b0) bad++;
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL hold_retrigger got %0d busy/out cycles want 0", bad);
    end
    vectors++;
    if (cup_count !== 16'd1) begin
      miscompares++;
      $display("FAIL hold_count got %0d want 1", cup_count);
    end
    coffee_make = 1'b0;
    tick();
  endtask

  task automatic test_edge_in_brew();
    int pulses = 0;
    int out_at = 0;
    coffee_make = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (coffee_out === 1'b1) begin pulses++; out_at = k; end
      if (k == 25) coffee_make = 1'b0;
      if (k == 27) coffee_make = 1'b1;
    end
    vectors++;
    if (pulses !== 1 || out_at !== 61) begin
      miscompares++;
      $display("FAIL brew_edge got pulses=%0d at=%0d want 1 at 61", pulses, out_at);
    end
    vectors++;
    if (cup_count !== 16'd2) begin
      miscompares++;
      $display("FAIL brew_edge_count got %0d want 2", cup_count);
    end
    coffee_make = 1'b0;
    tick();
  endtask

  task automatic test_cup_check();
`ifdef DISPENSER_CUP_CHECK_EN
    coffee_make = 1'b1; cup_present = 1'b1;
    for (int k = 1; k <= 27; k++) begin
      tick();
      if (k == 25) begin
        vectors++;
        if (pump_on !== 1'b1) begin
          miscompares++;
          $display("FAIL cup_brew5_pump got %b want 1", pump_on);
        end
        cup_present = 1'b0;
      end
      if (k == 26) begin
        vectors++;
        if ({heater_on, pump_on, valve_on, coffee_out, fault, busy} !== 6'b000111 ||
            cup_count !== 16'd2) begin
          miscompares++;
          $display("FAIL cup_abort got hpvofb=%b count=%0d want 000111 2",
                   {heater_on, pump_on, valve_on, coffee_out, fault, busy}, cup_count);
        end
      end
    end
    vectors++;
    if (coffee_out !== 1'b0 || busy !== 1'b0 || fault !== 1'b1) begin
      miscompares++;
      $display("FAIL cup_after_abort got out=%b busy=%b fault=%b want 0 0 1",
               coffee_out, busy, fault);
    end
    coffee_make = 1'b0;
    tick();
    coffee_make = 1'b1;
    tick();
    vectors++;
    if (coffee_out !== 1'b1 || fault !== 1'b1 || heater_on !== 1'b0) begin
      miscompares++;
      $display("FAIL cup_idle_abort got out=%b fault=%b heat=%b want 1 1 0",
               coffee_out, fault, heater_on);
    end
    coffee_make = 1'b0; cup_present = 1'b1;
    tick();
    vectors++;
    if (fault !== 1'b1 || coffee_out !== 1'b0) begin
      miscompares++;
      $display("FAIL cup_fault_sticky got fault=%b out=%b want 1 0", fault, coffee_out);
    end
    coffee_make = 1'b1;
    tick();
    vectors++;
    if (heater_on !== 1'b1 || fault !== 1'b0) begin
      miscompares++;
      $display("FAIL cup_fault_clear got heat=%b fault=%b want 1 0", heater_on, fault);
    end
    for (int k = 2; k <= 61; k++) tick();
`else
    int fault_seen = 0;
    coffee_make = 1'b1; cup_present = 1'b0;
    for (int k = 1; k <= 61; k++) begin
      tick();
      if (fault !== 1'b0) fault_seen++;
    end
    vectors++;
    if (fault_seen !== 0) begin
      miscompares++;
      $display("FAIL nocheck_fault got %0d cycles high want 0", fault_seen);
    end
`endif
    vectors++;
    if (coffee_out !== 1'b1 || cup_count !== 16'd3) begin
      miscompares++;
      $display("FAIL cup_final got out=%b count=%0d want 1 3", coffee_out, cup_count);
    end
    coffee_make = 1'b0; cup_present = 1'b1;
    tick();
  endtask

  task automatic test_reset_mid_pour();
    int pulses = 0;
    tick();
    coffee_make = 1'b1;
    for (int k = 1; k <= 55; k++) tick();
    vectors++;
    if (valve_on !== 1'b1) begin
      miscompares++;
      $display("FAIL pour_reached got valve=%b want 1", valve_on);
    end
    coffee_make = 1'b0;
    reset = 1'b1;
    tick();
    vectors++;
    if ({coffee_out, busy, heater_on, pump_on, valve_on, fault} !== 6'b000000 ||
        cup_count !== 16'd0) begin
      miscompares++;
      $display("FAIL pour_reset got %b count=%0d want 000000 0",
               {coffee_out, busy, heater_on, pump_on, valve_on, fault}, cup_count);
    end
    reset = 1'b0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (coffee_out === 1'b1 || busy === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      miscompares++;
      $display("FAIL pour_reset_quiet got %0d active cycles want 0", pulses);
    end
  endtask

  task automatic test_make_high_at_reset();
    reset = 1'b1; coffee_make = 1'b1;
    tick(); tick();
    reset = 1'b0;
    tick();
    vectors++;
    if (heater_on !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_edge got heat=%b busy=%b want 1 1", heater_on, busy);
    end
    for (int k = 2; k <= 61; k++) tick();
    vectors++;
    if (coffee_out !== 1'b1 || cup_count !== 16'd1) begin
      miscompares++;
      $display("FAIL reset_edge_done got out=%b count=%0d want 1 1", coffee_out, cup_count);
    end
    coffee_make = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_dispense();
    test_hold_no_retrigger();
    test_edge_in_brew();
    test_cup_check();
    test_reset_mid_pour();
    test_make_high_at_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
